// File: rtl/cpu_run_ctrl.sv
// Run/step/breakpoint controller driving the CPU enable and start inputs.
// Define CPU_RUN_CTRL_CYCLE_CNT_EN to build the saturating enabled-cycle counter; otherwise cycles reads 0.
module cpu_run_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int STEP_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_btn,
  input  logic [1:0]        mode,
  input  logic [STEP_W-1:0] step_count,
  input  logic              bp_en,
  input  logic [ADDR_W-1:0] bp_addr,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] y_in,
  output logic              cpu_enable,
  output logic              cpu_start,
  output logic              running,
  output logic              bp_hit,
  output logic [CNT_W-1:0]  cycles,
  output logic [DATA_W-1:0] y_snap
);

  typedef enum logic [1:0] {IDLE, RUN, STEP, DONE} state_t;

  state_t            state, state_nx;
  logic              btn_p0, btn_p1, btn_p2;
  logic              btn_edge;
  logic              first_p, first_nx;
  logic [STEP_W-1:0] remaining, remaining_nx;
  logic              start_nx, bp_hit_nx, bp_cond, snap_en, active_nx;

  assign btn_edge = btn_p1 & ~btn_p2;
  // The first enabled cycle after entry is masked so the CPU can leave a breakpoint address.
  assign bp_cond  = bp_en & (i_addr == bp_addr) & ~first_p;

  always_comb begin
    state_nx     = state;
    remaining_nx = remaining;
    start_nx     = 1'b0;
    bp_hit_nx    = bp_hit;
    case (state)
      IDLE, DONE: begin
        if (btn_edge) begin
          case (mode)
            2'b00: state_nx = IDLE;
            2'b01: begin
              state_nx = RUN;
              start_nx = (state == IDLE);
            end
            2'b10: begin
              state_nx     = STEP;
              remaining_nx = STEP_W'(1);
              start_nx     = (state == IDLE);
            end
            default: begin
              if (step_count != '0) begin
                state_nx     = STEP;
                remaining_nx = step_count;
                start_nx     = (state == IDLE);
              end
            end
          endcase
        end
        if (state_nx != DONE) bp_hit_nx = 1'b0;
      end
      RUN: begin
        if (btn_edge || mode == 2'b00 || bp_cond) begin
          state_nx  = DONE;
          bp_hit_nx = bp_cond;
        end
      end
      default: begin
        remaining_nx = remaining - 1'b1;
        if (btn_edge || mode == 2'b00 || bp_cond || remaining == STEP_W'(1)) begin
          state_nx     = DONE;
          remaining_nx = '0;
          bp_hit_nx    = bp_cond;
        end
      end
    endcase
    active_nx = (state_nx == RUN) || (state_nx == STEP);
    first_nx  = active_nx && (state != RUN) && (state != STEP);
    snap_en   = (state_nx == DONE) && (state != DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      btn_p0     <= 1'b0;
      btn_p1     <= 1'b0;
      btn_p2     <= 1'b0;
      cpu_enable <= 1'b0;
      cpu_start  <= 1'b0;
      running    <= 1'b0;
      bp_hit     <= 1'b0;
      first_p    <= 1'b0;
      remaining  <= '0;
      y_snap     <= '0;
    end else begin
      btn_p0     <= start_btn;
      btn_p1     <= btn_p0;
      btn_p2     <= btn_p1;
      state      <= state_nx;
      cpu_enable <= active_nx;
      cpu_start  <= start_nx;
      running    <= active_nx;
      bp_hit     <= bp_hit_nx;
      first_p    <= first_nx;
      remaining  <= remaining_nx;
      if (snap_en) y_snap <= y_in;
    end
  end

`ifdef CPU_RUN_CTRL_CYCLE_CNT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst)             cycles <= '0;
    else if (cpu_enable) cycles <= sat_inc(cycles);
  end
`else
  assign cycles = '0;
`endif

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl (CNT_W=4 so counter saturation is reachable).
module tb_cpu_run_ctrl;

`ifdef CPU_RUN_CTRL_CYCLE_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_btn = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [7:0]  step_count = 8'd0;
  logic        bp_en = 1'b0;
  logic [7:0]  bp_addr = 8'd0;
  logic [7:0]  i_addr = 8'd0;
  logic [15:0] y_in = 16'd0;
  logic        cpu_enable, cpu_start, running, bp_hit;
  logic [3:0]  cycles;
  logic [15:0] y_snap;

  int errors = 0;
  int checks = 0;

  cpu_run_ctrl #(.ADDR_W(8), .DATA_W(16), .STEP_W(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .start_btn(start_btn), .mode(mode),
    .step_count(step_count), .bp_en(bp_en), .bp_addr(bp_addr),
    .i_addr(i_addr), .y_in(y_in), .cpu_enable(cpu_enable),
    .cpu_start(cpu_start), .running(running), .bp_hit(bp_hit),
    .cycles(cycles), .y_snap(y_snap)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Button sampled at edge k, FSM acts at edge k+2; returns just after k+2.
  task automatic press();
    start_btn = 1'b1;
    tick();
    start_btn = 1'b0;
    tick();
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_cyc(input int n);
    return CNT_ON ? 32'(n) : 32'd0;
  endfunction

  logic en_prev;
  int   n_en;

  initial begin
    tick();
    do_reset();
    check("rst_enable", 32'(cpu_enable), 32'd0);
    check("rst_start", 32'(cpu_start), 32'd0);
    check("rst_running", 32'(running), 32'd0);
    check("rst_bp_hit", 32'(bp_hit), 32'd0);
    check("rst_cycles", 32'(cycles), 32'd0);
    check("rst_y_snap", 32'(y_snap), 32'd0);

    // Free run start, then stop with a second press.
    mode = 2'b01;
    y_in = 16'h1234;
    press();
    check("run_start", 32'(cpu_start), 32'd1);
    check("run_enable", 32'(cpu_enable), 32'd1);
    check("run_running", 32'(running), 32'd1);
    tick();
    check("run_start_pulse", 32'(cpu_start), 32'd0);
    check("run_enable_hold", 32'(cpu_enable), 32'd1);
    check("run_cycles1", 32'(cycles), exp_cyc(1));
    y_in = 16'hBEEF;
    press();
    check("stop_enable", 32'(cpu_enable), 32'd0);
    check("stop_running", 32'(running), 32'd0);
    check("stop_y_snap", 32'(y_snap), 32'hBEEF);
    check("stop_bp_hit", 32'(bp_hit), 32'd0);
    check("stop_cycles", 32'(cycles), exp_cyc(4));

    // N-step with N=5.
    do_reset();
    mode = 2'b11;
    step_count = 8'd5;
    press();
    check("nstep_start", 32'(cpu_start), 32'd1);
    step_count = 8'd9;
    n_en = 0;
    for (int i = 0; i < 20; i++) begin
      if (cpu_enable) n_en++;
      tick();
    end
    check("nstep_count", 32'(n_en), 32'd5);
    check("nstep_running", 32'(running), 32'd0);
    check("nstep_cycles", 32'(cycles), exp_cyc(5));

    // N-step with N=0 does nothing.
    do_reset();
    step_count = 8'd0;
    press();
    check("n0_start", 32'(cpu_start), 32'd0);
    check("n0_enable", 32'(cpu_enable), 32'd0);
    tick();
    check("n0_running", 32'(running), 32'd0);

    // Single step: exactly one enabled cycle.
    mode = 2'b10;
    press();
    check("ss_enable", 32'(cpu_enable), 32'd1);
    check("ss_start", 32'(cpu_start), 32'd1);
    tick();
    check("ss_done_enable", 32'(cpu_enable), 32'd0);
    check("ss_done_running", 32'(running), 32'd0);

    // Breakpoint at 0x10 with a ramping instruction address.
    do_reset();
    mode = 2'b01;
    bp_en = 1'b1;
    bp_addr = 8'h10;
    i_addr = 8'h00;
    y_in = 16'hA000;
    press();
    for (int i = 0; i < 40 && running; i++) begin
      en_prev = cpu_enable;
      y_in = 16'hA000 | 16'(i_addr);
      tick();
      if (en_prev) i_addr = i_addr + 8'd1;
    end
    check("bp_running", 32'(running), 32'd0);
    check("bp_hit", 32'(bp_hit), 32'd1);
    check("bp_addr_after", 32'(i_addr), 32'h11);
    check("bp_y_snap", 32'(y_snap), 32'hA010);
    check("bp_cycles_sat", 32'(cycles), exp_cyc(15));

    // Resume sitting on the breakpoint address.
    i_addr = 8'h10;
    press();
    check("resume_running", 32'(running), 32'd1);
    check("resume_bp_clear", 32'(bp_hit), 32'd0);
    check("resume_no_start", 32'(cpu_start), 32'd0);
    tick();
    check("resume_masked", 32'(running), 32'd1);
    tick();
    check("rehalt_running", 32'(running), 32'd0);
    check("rehalt_bp_hit", 32'(bp_hit), 32'd1);
    check("cycles_no_wrap", 32'(cycles), exp_cyc(15));

    // Reset in the middle of an N-step run.
    do_reset();
    bp_en = 1'b0;
    mode = 2'b11;
    step_count = 8'd6;
    press();
    tick();
    tick();
    tick();
    check("midstep_enable", 32'(cpu_enable), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mode = 2'b00;
    check("midrst_enable", 32'(cpu_enable), 32'd0);
    check("midrst_running", 32'(running), 32'd0);
    check("midrst_start", 32'(cpu_start), 32'd0);
    check("midrst_cycles", 32'(cycles), 32'd0);
    check("midrst_y_snap", 32'(y_snap), 32'd0);
    n_en = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (cpu_enable) n_en++;
    end
    check("midrst_quiet", 32'(n_en), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
